// File: rtl/jt1943_rom_pkg.sv
// Shared constants and line alignment helper
// for the jt1943 ROM request cache.
package jt1943_rom_pkg;

    localparam int LINE_W = 32;
    localparam int SLOTS  = 2;

    // Clear the sub-word bits so the address points at a 32-bit line
    function automatic logic [31:0] line_align(
        input logic [31:0] a,
        input int          dw
    );
        logic [31:0] r;
        r = a;
        if (dw == 8) begin
            r[1:0] = 2'b00;
        end else if (dw == 16) begin
            r[0] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/jt1943_rom_req_sel.sv
// Sub-word mux: picks the DW-bit word out of a 32-bit line,
// optionally swapping on address bit 0.
module jt1943_rom_req_sel
    import jt1943_rom_pkg::*;
#(
    parameter int DW        = 8,
    parameter bit INVERT_A0 = 1'b0
) (
    input  logic [LINE_W-1:0] line,
    input  logic [1:0]        a_lo,
    output logic [DW-1:0]     dout
);

    logic unused_lo;
    assign unused_lo = &{1'b0, a_lo};

    generate
        if (DW == 8) begin : g_b8
            logic [1:0] sel;
            assign sel = a_lo ^ {1'b0, INVERT_A0};
            // Byte select within the line
            always_comb begin
                dout = line[7:0];
                unique case (sel)
                    2'd0: dout = line[7:0];
                    2'd1: dout = line[15:8];
                    2'd2: dout = line[23:16];
                    2'd3: dout = line[31:24];
                    default: dout = line[7:0];
                endcase
            end
        end else if (DW == 16) begin : g_b16
            logic sel;
            assign sel = a_lo[0] ^ INVERT_A0;
            // Half-word select within the line
            always_comb begin
                dout = sel ? line[31:16] : line[15:0];
            end
        end else begin : g_b32
            // Whole line is the word
            always_comb begin
                dout = line[DW-1:0];
            end
        end
    endgenerate

endmodule

// File: rtl/jt1943_rom_req.sv
// Two-slot ROM line cache in front of the SDRAM arbiter.
// Optional JT1943_ROMRQ_STATS_EN adds simulation hit-rate counters.
module jt1943_rom_req
    import jt1943_rom_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter bit INVERT_A0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [AW-1:0]     addr,
    input  logic              addr_ok,
    output logic [AW-1:0]     addr_req,
    input  logic [LINE_W-1:0] din,
    output logic [DW-1:0]     dout,
    output logic              req,
    input  logic              we
);

    logic [AW-1:0]     tag_q  [SLOTS];
    logic [AW-1:0]     tag_d  [SLOTS];
    logic [LINE_W-1:0] data_q [SLOTS];
    logic [LINE_W-1:0] data_d [SLOTS];
    logic [SLOTS-1:0]  valid_q, valid_d;
    logic              vic_q, vic_d;

    logic [31:0]       addr_ext;
    logic              hit0, hit1, hit;
    logic              tgt;
    logic [LINE_W-1:0] line;

    assign addr_ext = 32'(addr);
    assign addr_req = AW'(line_align(addr_ext, DW));

    assign hit0 = valid_q[0] & (tag_q[0] == addr_req);
    assign hit1 = valid_q[1] & (tag_q[1] == addr_req);
    assign hit  = hit0 | hit1;
    assign req  = addr_ok & ~hit;

    // Line driven to the mux: slot 0 wins if both hit
    always_comb begin
        line = '0;
        if (hit0) begin
            line = data_q[0];
        end else if (hit1) begin
            line = data_q[1];
        end
    end

    jt1943_rom_req_sel #(
        .DW        (DW),
        .INVERT_A0 (INVERT_A0)
    ) u_sel (
        .line (line),
        .a_lo (addr_ext[1:0]),
        .dout (dout)
    );

    // Fill: refresh the hitting slot, else replace the victim
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        vic_d   = vic_q;
        tgt     = hit0 ? 1'b0 : (hit1 ? 1'b1 : vic_q);
        if (cen && we) begin
            tag_d[tgt]   = addr_req;
            data_d[tgt]  = din;
            valid_d[tgt] = 1'b1;
            if (!hit) begin
                vic_d = ~vic_q;
            end
        end
    end

    // Cache state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SLOTS; k++) begin
                tag_q[k]  <= '0;
                data_q[k] <= '0;
            end
            valid_q <= '0;
            vic_q   <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            vic_q   <= vic_d;
        end
    end

`ifdef JT1943_ROMRQ_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] misses_q;
    logic [31:0] lookups_n;
    logic [31:0] misses_n;

    assign lookups_n = lookups_q + 32'd1;
    assign misses_n  = misses_q + {31'd0, req};

    // Lookup/miss counters with periodic hit-rate report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookups_q <= '0;
            misses_q  <= '0;
        end else if (cen) begin
            if (addr_ok) begin
                lookups_q <= lookups_n;
                if (lookups_n[15:0] == 16'd0) begin
                    $display("ROMRQ hit rate %d%%",
                        ((lookups_n - misses_n) * 32'd100)
                        / lookups_n);
                end
            end
            misses_q <= misses_n;
        end
    end
`endif

endmodule

// File: tb/tb_jt1943_rom_req.sv
// Directed bench for jt1943_rom_req: byte, inverted-byte
// and 32-bit word configurations side by side.
module tb_jt1943_rom_req;

    logic        clk;
    logic        rst_n;
    logic        cen;
    logic        we;
    logic [31:0] din;

    logic [7:0]  addr;
    logic        addr_ok;
    logic [7:0]  addr_req;
    logic [7:0]  dout;
    logic        req;

    logic [7:0]  addr_req_i;
    logic [7:0]  dout_i;
    logic        req_i;

    logic [12:0] addr32;
    logic        ok32;
    logic        we32;
    logic [12:0] addr_req32;
    logic [31:0] dout32;
    logic        req32;

    int n_tot;
    int n_fail;

    jt1943_rom_req #(.AW(8), .DW(8), .INVERT_A0(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .addr(addr), .addr_ok(addr_ok), .addr_req(addr_req),
        .din(din), .dout(dout), .req(req), .we(we)
    );

    jt1943_rom_req #(.AW(8), .DW(8), .INVERT_A0(1'b1)) u_inv (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .addr(addr), .addr_ok(addr_ok), .addr_req(addr_req_i),
        .din(din), .dout(dout_i), .req(req_i), .we(we)
    );

    jt1943_rom_req #(.AW(13), .DW(32), .INVERT_A0(1'b0)) u_w32 (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .addr(addr32), .addr_ok(ok32), .addr_req(addr_req32),
        .din(din), .dout(dout32), .req(req32), .we(we32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] d);
        din = d;
        we  = 1'b1;
        step();
        we  = 1'b0;
    endtask

    initial begin
        n_tot   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        cen     = 1'b1;
        we      = 1'b0;
        we32    = 1'b0;
        din     = '0;
        addr    = 8'h05;
        addr_ok = 1'b1;
        addr32  = 13'h1234;
        ok32    = 1'b1;
        #1;
        check("rst_req", 32'(req), 32'd1);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_areq", 32'(addr_req), 32'h04);
        step();
        rst_n = 1'b1;
        #1;
        check("t1_req", 32'(req), 32'd1);
        check("t1_areq", 32'(addr_req), 32'h04);
        check("t1_dout", 32'(dout), 32'h0);
        check("t4_areq", 32'(addr_req32), 32'h1234);
        check("t4_req", 32'(req32), 32'd1);

        fill(32'hDDCCBBAA);
        check("t2_req", 32'(req), 32'd0);
        check("t2_dout", 32'(dout), 32'hBB);
        check("t2_inv", 32'(dout_i), 32'hAA);

        addr = 8'h08;
        #1;
        check("t3_miss08", 32'(req), 32'd1);
        fill(32'h44332211);
        addr = 8'h0A;
        #1;
        check("t3_req0a", 32'(req), 32'd0);
        check("t3_dout0a", 32'(dout), 32'h33);
        check("t3_inv0a", 32'(dout_i), 32'h44);
        addr = 8'h04;
        #1;
        check("t3_hit04", 32'(dout), 32'hAA);

        addr = 8'h0C;
        #1;
        check("t3_miss0c", 32'(req), 32'd1);
        fill(32'h88776655);
        check("t3_dout0c", 32'(dout), 32'h55);
        addr = 8'h04;
        #1;
        check("t3_evict04", 32'(req), 32'd1);
        check("t3_dout04", 32'(dout), 32'h0);
        addr = 8'h09;
        #1;
        check("t3_keep08", 32'(dout), 32'h22);

        addr = 8'h08;
        fill(32'hAABBCCDD);
        check("refresh08", 32'(dout), 32'hDD);
        addr = 8'h10;
        fill(32'hF0E0D0C0);
        check("fill10", 32'(dout), 32'hC0);
        addr = 8'h0C;
        #1;
        check("keep0c", 32'(req), 32'd0);
        addr = 8'h08;
        #1;
        check("evict08", 32'(req), 32'd1);

        addr    = 8'h20;
        addr_ok = 1'b0;
        #1;
        check("t5_noreq", 32'(req), 32'd0);
        fill(32'h01020304);
        addr_ok = 1'b1;
        #1;
        check("t5_okfill", 32'(req), 32'd0);
        check("t5_dout20", 32'(dout), 32'h04);
        addr = 8'h23;
        #1;
        check("t5_dout23", 32'(dout), 32'h01);

        rst_n = 1'b0;
        #1;
        check("t5_rst_dout", 32'(dout), 32'h0);
        check("t5_rst_req", 32'(req), 32'd1);
        check("t5_rst_areq", 32'(addr_req), 32'h20);
        step();
        rst_n = 1'b1;
        #1;
        check("t5_post_req", 32'(req), 32'd1);

        cen = 1'b0;
        din = 32'h55555555;
        we  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_cen0", 32'(req), 32'd1);
        end
        we  = 1'b0;
        cen = 1'b1;
        step();
        check("t6_after", 32'(req), 32'd1);
        check("t6_dout", 32'(dout), 32'h0);

        din  = 32'hCAFEF00D;
        we32 = 1'b1;
        step();
        we32 = 1'b0;
        check("t4_dout", dout32, 32'hCAFEF00D);
        check("t4_hit", 32'(req32), 32'd0);

        $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
        $finish;
    end

endmodule
